mmio_uart_ctrl: RTL

MMIO_UART_CTRL -- requirements
Module: mmio_uart_ctrl

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_uart_fifo.sv | 57 +++++
 rtl/mmio_uart_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants, FSM state type and MMIO write payload for the MMIO UART controller.
package mmio_pkg;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned CKDIV_W = 32;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [ADDR_W-1:0]  ADDR_UART = 9'h000;
    localparam logic [ADDR_W-1:0]  ADDR_LED  = 9'h001;
    localparam logic [ADDR_W-1:0]  ADDR_CTRL = 9'h002;

    localparam logic [CKDIV_W-1:0] CKDIV_RST_DEF = 32'h0000_01B1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } mmio_wr_t;

endpackage

// File: rtl/mmio_uart_fifo.sv
// Synchronous byte FIFO; a push while full is accepted when a pop happens in the same cycle.
module mmio_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = push && (!full || pop);
    assign rd_ok = pop && !empty;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO-programmed UART transmitter with LED register and sticky overflow flag.
// Macro MMIO_UART_FIFO_EN selects a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register.
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter logic [CKDIV_W-1:0]  CKDIV_RST  = CKDIV_RST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              uart_tx,
    output logic [BYTE_W-1:0] led,
    output logic              tx_busy,
    output logic              tx_full,
    output logic              tx_ovf
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mmio_uart_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    mmio_wr_t           wr;
    logic               ckdiv_we_c;
    logic               push_c;
    logic               led_we_c;
    logic               ovf_clr_c;
    logic               ovf_set_c;
    logic               pop_c;
    logic               fifo_full;
    logic               fifo_empty;
    logic [BYTE_W-1:0]  head;
    logic [CKDIV_W-1:0] ckdiv;

    uart_state_e        state, state_nx;
    logic [CKDIV_W-1:0] cnt, cnt_nx;
    logic [2:0]         idx, idx_nx;
    logic [BYTE_W-1:0]  sh, sh_nx;
    logic               tx_nx;

    assign wr = '{en: W0_en, addr: W0_addr, data: W0_data, mask: W0_mask};

    wire unused_data = &{1'b0, wr.data[DATA_W-1:40]};

    // Write decode; a lane group with a partial mask is ignored
    assign ckdiv_we_c = wr.en && (wr.addr == ADDR_UART) && (wr.mask[3:0] == 4'hF);
    assign push_c     = wr.en && (wr.addr == ADDR_UART) && (wr.mask[7:4] == 4'hF);
    assign led_we_c   = wr.en && (wr.addr == ADDR_LED)  && wr.mask[0];
    assign ovf_clr_c  = wr.en && (wr.addr == ADDR_CTRL) && wr.mask[0] && wr.data[0];
    assign ovf_set_c  = push_c && fifo_full && !pop_c;

`ifdef MMIO_UART_FIFO_EN
    mmio_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (wr.data[39:32]),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    logic              hold_valid;
    logic [BYTE_W-1:0] hold_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
        end else if (push_c && (!hold_valid || pop_c)) begin
            hold_valid <= 1'b1;
            hold_byte  <= wr.data[39:32];
        end else if (pop_c) begin
            hold_valid <= 1'b0;
        end
    end

    assign fifo_full  = hold_valid;
    assign fifo_empty = !hold_valid;
    assign head       = hold_byte;
`endif

    assign tx_busy = (state != ST_IDLE) || !fifo_empty;
    assign tx_full = fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckdiv  <= CKDIV_RST;
            led    <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (ckdiv_we_c) begin
                ckdiv <= wr.data[31:0];
            end
            if (led_we_c) begin
                led <= wr.data[7:0];
            end
            if (ovf_set_c) begin
                tx_ovf <= 1'b1;
            end else if (ovf_clr_c) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            idx     <= idx_nx;
            sh      <= sh_nx;
            uart_tx <= tx_nx;
        end
    end

    // Frame sequencing; every bit start reloads the counter from the current ckdiv
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sh_nx    = sh;
        tx_nx    = uart_tx;
        pop_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    pop_c    = 1'b1;
                    sh_nx    = head;
                    cnt_nx   = ckdiv;
                    tx_nx    = 1'b0;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    idx_nx   = '0;
                    cnt_nx   = ckdiv;
                    tx_nx    = sh[0];
                    state_nx = ST_DATA;
                end else begin
                    cnt_nx = cnt - CKDIV_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    cnt_nx = ckdiv;
                    if (idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = ST_STOP;
                    end else begin
                        idx_nx = idx + 3'(1);
                        sh_nx  = {1'b0, sh[BYTE_W-1:1]};
                        tx_nx  = sh[1];
                    end
                end else begin
                    cnt_nx = cnt - CKDIV_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    if (!fifo_empty) begin
                        pop_c    = 1'b1;
                        sh_nx    = head;
                        cnt_nx   = ckdiv;
                        tx_nx    = 1'b0;
                        state_nx = ST_START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CKDIV_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
